// File: rtl/dmem_hs.sv
// dmem_hs: byte-addressed little-endian data memory with valid/ready request and
// response handshakes, a registered read path and func3/alignment/range fault detection.
module dmem_hs #(
    parameter int DEPTH_BYTES = 64,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault
);

    localparam int IDX_W = $clog2(DEPTH_BYTES);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, state_nx;

    logic              accept;
    logic              in_access;

    logic              lat_we;
    logic [2:0]        lat_func3;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;

    logic              size_b, size_h, size_w, func3_ok;
    logic              misaligned, out_of_range, fault;

    logic [IDX_W-1:0]  base_idx;
    logic [7:0]        rd_lane [4];
    logic [31:0]       rd_word;
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;
    logic [31:0]       load_data;

    logic [3:0]        wr_be;
    logic [31:0]       wr_word;
    logic              do_write;

    // Zero at power-up only; rst leaves the contents alone.
    logic [7:0] mem [DEPTH_BYTES] = '{default: 8'h00};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid) state_nx = ACCESS;
            ACCESS:  state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        in_access = (state == ACCESS);
        accept    = req_valid && (state == IDLE);
    end

    // Request fields are sampled only at acceptance; the ACCESS cycle works on these copies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_we    <= 1'b0;
            lat_func3 <= 3'b000;
            lat_addr  <= '0;
            lat_wdata <= 32'h0;
        end else if (accept) begin
            lat_we    <= req_we;
            lat_func3 <= req_func3;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end
    end

    always_comb begin
        size_b   = 1'b0;
        size_h   = 1'b0;
        size_w   = 1'b0;
        func3_ok = 1'b0;
        case (lat_func3)
            F3_B:  begin size_b = 1'b1; func3_ok = 1'b1;    end
            F3_H:  begin size_h = 1'b1; func3_ok = 1'b1;    end
            F3_W:  begin size_w = 1'b1; func3_ok = 1'b1;    end
            F3_BU: begin size_b = 1'b1; func3_ok = !lat_we; end
            F3_HU: begin size_h = 1'b1; func3_ok = !lat_we; end
            default: ;
        endcase
    end

    // Depth is a multiple of 4, so an aligned in-range access never crosses the top.
    assign misaligned   = (size_h && lat_addr[0]) || (size_w && (lat_addr[1:0] != 2'b00));
    assign out_of_range = ({1'b0, lat_addr} >= (ADDR_W + 1)'(DEPTH_BYTES));
    assign fault        = !func3_ok || misaligned || out_of_range;

    assign base_idx = {lat_addr[IDX_W-1:2], 2'b00};

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rd_lane[k] = mem[base_idx + IDX_W'(k)];
        end
    end

    assign rd_word  = {rd_lane[3], rd_lane[2], rd_lane[1], rd_lane[0]};
    assign sel_byte = rd_word[{lat_addr[1:0], 3'b000} +: 8];
    assign sel_half = lat_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = 32'h0;
        case (lat_func3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_W:    load_data = rd_word;
            F3_BU:   load_data = {24'h0, sel_byte};
            F3_HU:   load_data = {16'h0, sel_half};
            default: load_data = 32'h0;
        endcase
    end

    // Store data is replicated across lanes; the byte enables pick the lanes that land.
    always_comb begin
        wr_be   = 4'b0000;
        wr_word = lat_wdata;
        case (lat_func3)
            F3_B: begin
                wr_be[lat_addr[1:0]] = 1'b1;
                wr_word              = {4{lat_wdata[7:0]}};
            end
            F3_H: begin
                wr_be   = lat_addr[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{lat_wdata[15:0]}};
            end
            F3_W: begin
                wr_be   = 4'b1111;
                wr_word = lat_wdata;
            end
            default: ;
        endcase
    end

    // A reset during ACCESS forces IDLE before the edge, so the pending store never commits.
    assign do_write = in_access && lat_we && !fault;

    // NOTE: the memory array has no reset branch; clearing RAM would block RAM inference.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_be[k]) begin
                    mem[base_idx + IDX_W'(k)] <= wr_word[8*k +: 8];
                end
            end
        end
    end

    // Response registers load once in ACCESS and hold through any back-pressure in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_rdata <= 32'h0;
            rsp_fault <= 1'b0;
        end else if (in_access) begin
            rsp_fault <= fault;
            rsp_rdata <= (fault || lat_we) ? 32'h0 : load_data;
        end
    end

    hold_while_stalled: assert property (
        @(posedge clk) disable iff (rst)
        (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_rdata) && $stable(rsp_fault))
    );

    ready_valid_exclusive: assert property (
        @(posedge clk) disable iff (rst)
        !(req_ready && rsp_valid)
    );

endmodule

// File: tb/tb_dmem_hs.sv
// tb_dmem_hs: directed bench for dmem_hs; a byte-array model predicts each response and
// a compare process checks every valid response cycle against it.
module tb_dmem_hs;

    localparam int DEPTH = 64;
    localparam int AW    = 8;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_we    = 1'b0;
    logic [2:0]    req_func3 = 3'b000;
    logic [AW-1:0] req_addr  = '0;
    logic [31:0]   req_wdata = 32'h0;
    logic          rsp_ready = 1'b1;
    logic          req_ready;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_fault;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
    } rsp_t;

    rsp_t       exp_q[$];
    logic [7:0] model_mem [DEPTH];

    dmem_hs #(
        .DEPTH_BYTES(DEPTH),
        .ADDR_W     (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_func3(req_func3),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_fault(rsp_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Plain memory model: size/alignment/range rules, then little-endian byte gather or scatter.
    function automatic void model_access(input logic we, input logic [2:0] f3, input int a,
                                         input logic [31:0] wd,
                                         output logic [31:0] rd, output logic flt);
        int          size;
        logic [31:0] v;
        size = 0;
        v    = 32'h0;
        case (f3)
            3'b000:  size = 1;
            3'b001:  size = 2;
            3'b010:  size = 4;
            3'b100:  size = we ? 0 : 1;
            3'b101:  size = we ? 0 : 2;
            default: size = 0;
        endcase
        flt = (size == 0) || (a >= DEPTH);
        if (!flt && (a % size) != 0) flt = 1'b1;
        rd = 32'h0;
        if (!flt) begin
            if (we) begin
                for (int i = 0; i < size; i++) model_mem[a + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < size; i++) v = v | (32'(model_mem[a + i]) << (8 * i));
                if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
                if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
                rd = v;
            end
        end
    endfunction

    // One transaction: accept, check latency, optionally stall the response, then check return to IDLE.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [7:0] a,
                          input logic [31:0] wd, input logic [31:0] lit_rd, input logic lit_flt,
                          input int hold, input string tag);
        logic [31:0] m_rd;
        logic        m_flt;
        int          n;
        rsp_ready = (hold == 0);
        req_valid = 1'b1;
        req_we    = we;
        req_func3 = f3;
        req_addr  = a;
        req_wdata = wd;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " req_ready before accept"}, req_ready, 1);
        @(posedge clk);
        model_access(we, f3, int'(a), wd, m_rd, m_flt);
        check({tag, " model rdata"}, m_rd, lit_rd);
        check({tag, " model fault"}, m_flt, lit_flt);
        exp_q.push_back('{m_rd, m_flt});
        #1;
        req_valid = 1'b0;
        req_we    = ~we;
        req_func3 = ~f3;
        req_addr  = ~a;
        req_wdata = ~wd;
        @(negedge clk);
        check({tag, " access rsp_valid"}, rsp_valid, 0);
        check({tag, " access req_ready"}, req_ready, 0);
        @(negedge clk);
        check({tag, " resp rsp_valid"}, rsp_valid, 1);
        if (hold > 0) begin
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_func3 = F_W;
            req_addr  = 8'd0;
            req_wdata = 32'h1234_5678;
            repeat (hold) begin
                @(negedge clk);
                check({tag, " stall rsp_valid"}, rsp_valid, 1);
                check({tag, " stall req_ready"}, req_ready, 0);
            end
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check({tag, " idle req_ready"}, req_ready, 1);
        check({tag, " idle rsp_valid"}, rsp_valid, 0);
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("response without request", rsp_valid, 0);
            end else begin
                check("rsp_rdata", rsp_rdata, exp_q[0].rdata);
                check("rsp_fault", rsp_fault, exp_q[0].fault);
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        foreach (model_mem[i]) model_mem[i] = 8'h00;

        #1;
        check("reset req_ready", req_ready, 1);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset rsp_rdata", rsp_rdata, 32'h0);
        check("reset rsp_fault", rsp_fault, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        do_req(1'b0, F_W,  8'd0,  32'h0,         32'h0000_0000, 1'b0, 0, "LW@0 after reset");
        do_req(1'b1, F_W,  8'd8,  32'h80FF_7F01, 32'h0000_0000, 1'b0, 0, "SW@8");
        do_req(1'b0, F_B,  8'd8,  32'h0,         32'h0000_0001, 1'b0, 0, "LB@8");
        do_req(1'b0, F_BU, 8'd8,  32'h0,         32'h0000_0001, 1'b0, 0, "LBU@8");
        do_req(1'b0, F_H,  8'd8,  32'h0,         32'h0000_7F01, 1'b0, 0, "LH@8");
        do_req(1'b0, F_H,  8'd10, 32'h0,         32'hFFFF_80FF, 1'b0, 0, "LH@10");
        do_req(1'b0, F_HU, 8'd10, 32'h0,         32'h0000_80FF, 1'b0, 0, "LHU@10");
        do_req(1'b0, F_W,  8'd8,  32'h0,         32'h80FF_7F01, 1'b0, 0, "LW@8");
        do_req(1'b0, F_B,  8'd11, 32'h0,         32'hFFFF_FF80, 1'b0, 0, "LB@11");
        do_req(1'b0, F_BU, 8'd11, 32'h0,         32'h0000_0080, 1'b0, 0, "LBU@11");

        do_req(1'b1, F_B,  8'd9,  32'h1234_56AA, 32'h0000_0000, 1'b0, 0, "SB@9");
        do_req(1'b0, F_W,  8'd8,  32'h0,         32'h80FF_AA01, 1'b0, 0, "LW@8 after SB");
        do_req(1'b1, F_W,  8'd12, 32'h1122_3344, 32'h0000_0000, 1'b0, 0, "SW@12");
        do_req(1'b1, F_H,  8'd13, 32'h0000_BEEF, 32'h0000_0000, 1'b1, 0, "SH@13 misaligned");
        do_req(1'b0, F_W,  8'd12, 32'h0,         32'h1122_3344, 1'b0, 0, "LW@12 unchanged");
        do_req(1'b1, F_H,  8'd14, 32'h0000_CAFE, 32'h0000_0000, 1'b0, 0, "SH@14");
        do_req(1'b0, F_W,  8'd12, 32'h0,         32'hCAFE_3344, 1'b0, 0, "LW@12 after SH");
        do_req(1'b0, F_HU, 8'd14, 32'h0,         32'h0000_CAFE, 1'b0, 0, "LHU@14");

        do_req(1'b0, F_W,    8'd2,   32'h0,         32'h0, 1'b1, 0, "LW@2 misaligned");
        do_req(1'b0, 3'b011, 8'd0,   32'h0,         32'h0, 1'b1, 0, "load func3 011");
        do_req(1'b1, 3'b100, 8'd0,   32'hFFFF_FFFF, 32'h0, 1'b1, 0, "store func3 100");
        do_req(1'b1, 3'b101, 8'd0,   32'hFFFF_FFFF, 32'h0, 1'b1, 0, "store func3 101");
        do_req(1'b0, F_B,    8'd64,  32'h0,         32'h0, 1'b1, 0, "LB@DEPTH");
        do_req(1'b0, F_B,    8'd255, 32'h0,         32'h0, 1'b1, 0, "LB@255");

        do_req(1'b1, F_W,  8'd60, 32'h5566_7788, 32'h0000_0000, 1'b0, 0, "SW@60 top word");
        do_req(1'b0, F_B,  8'd63, 32'h0,         32'h0000_0055, 1'b0, 0, "LB@63 top byte");
        do_req(1'b0, F_H,  8'd62, 32'h0,         32'h0000_5566, 1'b0, 0, "LH@62");
        do_req(1'b0, F_W,  8'd60, 32'h0,         32'h5566_7788, 1'b0, 0, "LW@60");
        do_req(1'b0, F_W,  8'd0,  32'h0,         32'h0000_0000, 1'b0, 0, "LW@0 after faults");

        do_req(1'b0, F_W,  8'd8,  32'h0,         32'h80FF_AA01, 1'b0, 5, "LW@8 back-pressure");

        // Store accepted, then reset lands mid-ACCESS: outputs clear at once and the store is lost.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_func3 = F_W;
        req_addr  = 8'd4;
        req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("mid-access reset req_ready", req_ready, 1);
        check("mid-access reset rsp_valid", rsp_valid, 0);
        check("mid-access reset rsp_rdata", rsp_rdata, 32'h0);
        check("mid-access reset rsp_fault", rsp_fault, 0);
        @(posedge clk);
        #1;
        check("reset held req_ready", req_ready, 1);
        check("reset held rsp_valid", rsp_valid, 0);
        rst = 1'b0;

        do_req(1'b0, F_W,  8'd4,  32'h0,         32'h0000_0000, 1'b0, 0, "LW@4 after dropped SW");
        do_req(1'b0, F_W,  8'd8,  32'h0,         32'h80FF_AA01, 1'b0, 0, "LW@8 survives reset");

        repeat (2) @(posedge clk);
        check("expected queue drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
